// File: rtl/sdp_select_pipe_pkg.sv
// Shared definitions for the select/shift datapath family.
//   SAT_TRUNC / SAT_CLAMP : narrowing mode constants (SAT parameter values)
//   fits_signed()         : narrowing helper shared by every narrowing block
package sdp_select_pipe_pkg;

  localparam int SAT_TRUNC   = 0;
  localparam int SAT_CLAMP   = 1;

  // Widest source the helper can inspect. Callers zero-extend into this width.
  localparam int NARROW_MAXW = 128;
  localparam int NARROW_IW   = $clog2(NARROW_MAXW);

  // Returns 1 when the low 'width' bits of v, read as a signed value, can be
  // represented in 'owidth' signed bits. That holds exactly when bits
  // [width-1:owidth-1] are all copies of the sign bit.
  function automatic logic fits_signed(input logic [NARROW_MAXW-1:0] v,
                                       input int width, input int owidth);
    logic ok;
    logic sgn;
    ok  = 1'b1;
    sgn = v[NARROW_IW'(width-1)];
    for (int i = 0; i < NARROW_MAXW; i++)
      if (i >= owidth-1 && i < width) ok = ok & (v[NARROW_IW'(i)] == sgn);
    return ok;
  endfunction

endpackage

// File: rtl/sdp_narrow.sv
// Combinational narrowing from WIDTH to OWIDTH bits.
//   din  : WIDTH-bit signed source
//   dout : OWIDTH-bit result; low bits (SAT_TRUNC) or signed-saturated (SAT_CLAMP)
module sdp_narrow
  import sdp_select_pipe_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int OWIDTH = 32,
  parameter int SAT    = SAT_TRUNC
) (
  input  logic [WIDTH-1:0]  din,
  output logic [OWIDTH-1:0] dout
);

  logic              fits;
  logic [OWIDTH-1:0] smin;

  assign fits = fits_signed(NARROW_MAXW'(din), WIDTH, OWIDTH);

  always_comb begin
    smin             = '0;
    smin[OWIDTH-1]   = 1'b1;
    dout             = din[OWIDTH-1:0];
    if (SAT == SAT_CLAMP && !fits)
      dout = din[WIDTH-1] ? smin : ~smin;
  end

endmodule

// File: rtl/sdp_select_pipe.sv
// Two-stage add/compare/select/shift pipeline with valid/ready on both sides.
//   CLK, RST            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake for a, b, c (WIDTH-bit signed)
//   out_valid/out_ready : output handshake for x, z (OWIDTH bits), lt, eq
// Stage 1 registers the selected g/h plus compare flags; stage 2 shifts by
// the flags, narrows and registers into the outputs.
module sdp_select_pipe
  import sdp_select_pipe_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int OWIDTH = 32,
  parameter int SAT    = SAT_TRUNC
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OWIDTH-1:0] x,
  output logic [OWIDTH-1:0] z,
  output logic              lt,
  output logic              eq
);

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] h;
    logic             lt;
    logic             eq;
  } s1_t;

  // vld_pipe[1] = stage-1 valid, vld_pipe[2] = output valid
  logic [2:1]        vld_pipe;
  s1_t               s1_n, s1_q;
  logic [WIDTH-1:0]  d, e, f;
  logic [WIDTH-1:0]  xs, zs;
  logic [OWIDTH-1:0] xn, zn;
  logic              out_adv, s1_adv;

  assign out_adv   = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || out_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe[2];

  // Stage 1: wrap-around arithmetic, signed compare, select
  always_comb begin
    d       = a + b;
    e       = a + c;
    f       = a - b;
    s1_n.lt = $signed(d) < $signed(e);
    s1_n.eq = (d == e);
    s1_n.g  = s1_n.lt ? e : d;
    s1_n.h  = s1_n.eq ? f : s1_n.g;
  end

  // Stage 2: shift amounts are the 1-bit flags, so only 0 or 1
  always_comb begin
    xs = s1_q.h << s1_q.lt;
    zs = $signed(s1_q.g) >>> s1_q.eq;
  end

  sdp_narrow #(.WIDTH(WIDTH), .OWIDTH(OWIDTH), .SAT(SAT)) u_nx (.din(xs), .dout(xn));
  sdp_narrow #(.WIDTH(WIDTH), .OWIDTH(OWIDTH), .SAT(SAT)) u_nz (.din(zs), .dout(zn));

  // Each stage loads only when it advances, which keeps stalled outputs stable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      x        <= '0;
      z        <= '0;
      lt       <= 1'b0;
      eq       <= 1'b0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= in_valid;
        s1_q        <= s1_n;
      end
      if (out_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        x           <= xn;
        z           <= zn;
        lt          <= s1_q.lt;
        eq          <= s1_q.eq;
      end
    end
  end

endmodule

// File: tb/tb_sdp_select_pipe.sv
module tb_sdp_select_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, out_ready;
  logic [63:0] a, b, c;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [31:0] x0, z0, x1, z1;
  logic        lt0, eq0, lt1, eq1;

  always #5 CLK = ~CLK;

  sdp_select_pipe #(.WIDTH(64), .OWIDTH(32), .SAT(0)) dut0 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .c(c), .out_valid(out_valid0), .out_ready(out_ready),
    .x(x0), .z(z0), .lt(lt0), .eq(eq0));

  sdp_select_pipe #(.WIDTH(64), .OWIDTH(32), .SAT(1)) dut1 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .c(c), .out_valid(out_valid1), .out_ready(out_ready),
    .x(x1), .z(z1), .lt(lt1), .eq(eq1));

  typedef struct {
    logic [63:0] a, b, c;
    logic [31:0] x0, z0, x1, z1;   // expected: truncating / saturating instance
    logic        lt, eq;
  } vec_t;

  localparam int NV = 8;
  vec_t tbl[NV];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input int i);
    chk({tag, ".x0"},  64'(x0),  64'(tbl[i].x0));
    chk({tag, ".z0"},  64'(z0),  64'(tbl[i].z0));
    chk({tag, ".x1"},  64'(x1),  64'(tbl[i].x1));
    chk({tag, ".z1"},  64'(z1),  64'(tbl[i].z1));
    chk({tag, ".lt0"}, 64'(lt0), 64'(tbl[i].lt));
    chk({tag, ".eq0"}, 64'(eq0), 64'(tbl[i].eq));
    chk({tag, ".lt1"}, 64'(lt1), 64'(tbl[i].lt));
    chk({tag, ".eq1"}, 64'(eq1), 64'(tbl[i].eq));
  endtask

  task automatic drive(input int i);
    in_valid = 1'b1;
    a = tbl[i].a; b = tbl[i].b; c = tbl[i].c;
  endtask

  // Streams vectors first..first+n-1 with out_ready low for cycles < stall_to.
  // Checks every output cycle against a FIFO model; reports held-output
  // cycles and how many accepts happened before in_ready first dropped.
  task automatic run_stream(input int first, input int n, input int stall_to,
                            output int holds, output int acc_at_drop);
    int exp_q[$];
    int sent = 0, recv = 0, cyc = 0;
    holds = 0; acc_at_drop = -1;
    while (recv < n && cyc < 100) begin
      @(negedge CLK);
      out_ready = (cyc >= stall_to);
      if (sent < n) drive(first + sent); else in_valid = 1'b0;
      #1;
      if (!in_ready0 && acc_at_drop < 0) acc_at_drop = sent;
      if (out_valid0) begin
        if (exp_q.size() == 0) chk("stream.spurious", 64'd1, 64'd0);
        else begin
          chk_vec(out_ready ? "stream.xfer" : "stream.hold", exp_q[0]);
          if (out_ready) begin void'(exp_q.pop_front()); recv++; end
          else holds++;
        end
      end
      if (in_valid && in_ready0) begin exp_q.push_back(first + sent); sent++; end
      cyc++;
    end
    chk("stream.delivered", 64'(recv), 64'(n));
    @(negedge CLK);
    in_valid = 1'b0;
    #1 chk("stream.drained", 64'(out_valid0), 64'd0);
  endtask

  initial begin
    int holds, acc_drop;
    tbl[0] = '{64'd5, 64'd3, 64'd10, 32'd30, 32'd15, 32'd30, 32'd15, 1'b1, 1'b0};
    tbl[1] = '{64'd4, 64'd6, 64'd6, 32'hFFFFFFFE, 32'd5, 32'hFFFFFFFE, 32'd5, 1'b0, 1'b1};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,
               32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h7FFFFFFF, 1'b1, 1'b0};
    tbl[3] = '{64'h0000_0100_0000_0000, 64'd0, 64'd1,
               32'd2, 32'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0};
    // d==e==-2^40: lt=0 picks g=d, eq picks h=f; both clamp low
    tbl[4] = '{64'hFFFF_FF00_0000_0000, 64'd0, 64'd0,
               32'd0, 32'd0, 32'h80000000, 32'h80000000, 1'b0, 1'b1};
    tbl[5] = '{64'd0, 64'd0, 64'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1};
    // d=-7, e=-1: g=h=-1
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFC, 64'd2,
               32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0};
    // d=15 > e=-10: no shifts
    tbl[7] = '{64'd10, 64'd5, 64'hFFFF_FFFF_FFFF_FFEC,
               32'd15, 32'd15, 32'd15, 32'd15, 1'b0, 1'b0};

    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst.out_valid0", 64'(out_valid0), 64'd0);
    chk("rst.out_valid1", 64'(out_valid1), 64'd0);
    chk("rst.x0", 64'(x0), 64'd0);
    chk("rst.z0", 64'(z0), 64'd0);
    chk("rst.lt_eq", 64'({lt0, eq0}), 64'd0);
    chk("rst.in_ready0", 64'(in_ready0), 64'd1);
    chk("rst.in_ready1", 64'(in_ready1), 64'd1);

    // Back-to-back table, out_ready high: result of vector n at cycle n+2.
    for (int n = 0; n < NV + 3; n++) begin
      if (n > 0) @(negedge CLK);
      out_ready = 1'b1;
      if (n < NV) drive(n); else in_valid = 1'b0;
      #1;
      chk("tbl.in_ready", 64'(in_ready0), 64'd1);
      if (n >= 2 && n - 2 < NV) begin
        chk("tbl.out_valid", 64'(out_valid0), 64'd1);
        chk_vec($sformatf("tbl[%0d]", n - 2), n - 2);
      end else begin
        chk("tbl.idle_valid", 64'(out_valid0), 64'd0);
      end
    end

    // Back-pressure: vectors 1,2,3 with out_ready low for 7 cycles
    // (out_valid rises in cycle 2, so vector 1 is held 5 cycles).
    run_stream(0, 3, 7, holds, acc_drop);
    chk("bp.hold_cycles", 64'(holds), 64'd5);
    chk("bp.accepts_before_drop", 64'(acc_drop), 64'd2);

    // Full-throughput stream across the whole table.
    run_stream(0, NV, 0, holds, acc_drop);
    chk("tput.no_hold", 64'(holds), 64'd0);
    chk("tput.never_blocked", 64'(acc_drop), 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset mid-stall with two results in flight.
    @(negedge CLK); out_ready = 1'b0; drive(2);
    @(negedge CLK); drive(3);
    @(negedge CLK); in_valid = 1'b0;
    #1 chk("rs.stalled_valid", 64'(out_valid0), 64'd1);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    #1;
    chk("rs.out_valid", 64'(out_valid0), 64'd0);
    chk("rs.x0", 64'(x0), 64'd0);
    chk("rs.z0", 64'(z0), 64'd0);
    chk("rs.x1", 64'(x1), 64'd0);
    chk("rs.z1", 64'(z1), 64'd0);
    chk("rs.in_ready", 64'(in_ready0), 64'd1);
    @(negedge CLK); out_ready = 1'b1; drive(6);
    #1 chk("rs.accept", 64'(in_ready0), 64'd1);
    @(negedge CLK); in_valid = 1'b0;
    #1 chk("rs.lat1_valid", 64'(out_valid0), 64'd0);
    @(negedge CLK);
    #1 chk("rs.lat2_valid", 64'(out_valid0), 64'd1);
    chk_vec("rs.new", 6);
    @(negedge CLK);
    #1 chk("rs.no_dup", 64'(out_valid0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
